// File: rtl/alu_operand_loader.sv
// Byte-serial operand loader for the multi-precision ALU.
// Assembles A then B little-endian and issues one command per load.
module alu_operand_loader #(
  parameter int unsigned IDLE_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  precision_sel,
  input  logic [2:0]  alu_op,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_prec,
  output logic [2:0]  cmd_op,
  output logic [31:0] cmd_a,
  output logic [31:0] cmd_b,
  output logic        busy,
  output logic        err_prec,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    ISSUE
  } state_t;

  localparam int unsigned SW =
    (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam logic [SW-1:0] TO_VAL = SW'(IDLE_TIMEOUT);
  localparam bit TO_EN = (IDLE_TIMEOUT != 0);

  state_t        state_q, state_d;
  logic [1:0]    prec_q, prec_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [SW-1:0] stall_inc;
  logic          eprec_q, eprec_d;
  logic          eto_q, eto_d;
  logic          xfer;
  logic [1:0]    last_new;
  logic [1:0]    last_cur;

  function automatic logic [1:0] last_idx(input logic [1:0] p);
    return (p == 2'b00) ? 2'd0 :
           (p == 2'b01) ? 2'd1 : 2'd3;
  endfunction

  assign byte_ready = (state_q != ISSUE);
  assign xfer       = byte_valid && byte_ready;
  assign last_new   = last_idx(precision_sel);
  assign last_cur   = last_idx(prec_q);
  assign stall_inc  = stall_q + 1'b1;

  always_comb begin
    state_d = state_q;
    prec_d  = prec_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    eprec_d = 1'b0;
    eto_d   = eto_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        stall_d = '0;
        if (xfer) begin
          if (precision_sel == 2'b11) begin
            eprec_d = 1'b1;
          end else begin
            prec_d = precision_sel;
            op_d   = alu_op;
            a_d    = {24'h0, byte_data};
            b_d    = '0;
            eto_d  = 1'b0;
            if (last_new == 2'd0) begin
              state_d = LOAD_B;
              cnt_d   = 2'd0;
            end else begin
              state_d = LOAD_A;
              cnt_d   = 2'd1;
            end
          end
        end
      end
      (state_q == LOAD_A),
      (state_q == LOAD_B): begin
        if (xfer) begin
          stall_d = '0;
          if (state_q == LOAD_A)
            a_d[{cnt_q, 3'b000} +: 8] = byte_data;
          else
            b_d[{cnt_q, 3'b000} +: 8] = byte_data;
          if (cnt_q == last_cur) begin
            cnt_d   = 2'd0;
            state_d = (state_q == LOAD_A) ? LOAD_B : ISSUE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (TO_EN) begin
          // Abort drops the partial operands so nothing stale is seen
          if (stall_inc == TO_VAL) begin
            state_d = IDLE;
            a_d     = '0;
            b_d     = '0;
            cnt_d   = 2'd0;
            stall_d = '0;
            eto_d   = 1'b1;
          end else begin
            stall_d = stall_inc;
          end
        end
      end
      (state_q == ISSUE): begin
        stall_d = '0;
        if (cmd_ready)
          state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prec_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      eprec_q <= 1'b0;
      eto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prec_q  <= prec_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      eprec_q <= eprec_d;
      eto_q   <= eto_d;
    end
  end

  assign cmd_valid   = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign cmd_prec    = prec_q;
  assign cmd_op      = op_q;
  assign cmd_a       = a_q;
  assign cmd_b       = b_q;
  assign err_prec    = eprec_q;
  assign err_timeout = eto_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: vector table plus scoreboard
// of expected commands, with hand-written corner sequences.
module tb_alu_operand_loader;

  logic        clk;
  logic        rst_n;
  logic [1:0]  precision_sel;
  logic [2:0]  alu_op;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_prec;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        busy;
  logic        err_prec;
  logic        err_timeout;

  alu_operand_loader #(.IDLE_TIMEOUT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .precision_sel(precision_sel),
    .alu_op(alu_op),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_prec(cmd_prec),
    .cmd_op(cmd_op),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .busy(busy),
    .err_prec(err_prec),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic [1:0]  prec;
    logic [2:0]  op;
    logic [63:0] bytes;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  typedef struct {
    logic [1:0]  prec;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  vec_t tbl[4];
  cmd_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_cmd got a=%h b=%h, required none",
                 cmd_a, cmd_b);
      end else begin
        cmd_t e;
        e = sb.pop_front();
        if (cmd_prec !== e.prec || cmd_op !== e.op ||
            cmd_a !== e.a || cmd_b !== e.b) begin
          n_err++;
          $display("FAIL cmd got p=%b op=%b a=%h b=%h, required p=%b op=%b a=%h b=%h",
                   cmd_prec, cmd_op, cmd_a, cmd_b, e.prec, e.op, e.a, e.b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int w;
    byte_valid = 1'b1;
    byte_data  = d;
    w = 0;
    while (!byte_ready && w < 50) begin
      tick();
      w++;
    end
    if (!byte_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_ready_wait got 0, required 1");
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic push(input logic [1:0] p, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    cmd_t c;
    c.prec = p;
    c.op   = op;
    c.a    = a;
    c.b    = b;
    sb.push_back(c);
  endtask

  task automatic send_vec(input vec_t v);
    int n;
    logic [63:0] bs;
    n  = (v.prec == 2'b00) ? 1 : (v.prec == 2'b01) ? 2 : 4;
    bs = v.bytes;
    push(v.prec, v.op, v.a, v.b);
    precision_sel = v.prec;
    alu_op        = v.op;
    for (int i = 0; i < 2 * n; i++)
      send_byte(bs[8*i +: 8]);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    tbl[0] = '{2'b00, 3'd0, 64'h0000_0000_0000_3412,
               32'h0000_0012, 32'h0000_0034};
    tbl[1] = '{2'b01, 3'd3, 64'h0000_0000_01EF_CDAB,
               32'h0000_CDAB, 32'h0000_01EF};
    tbl[2] = '{2'b10, 3'd5, 64'h0807_0605_0403_0201,
               32'h0403_0201, 32'h0807_0605};
    tbl[3] = '{2'b00, 3'd7, 64'h0000_0000_0000_00FF,
               32'h0000_00FF, 32'h0000_0000};

    rst_n = 1'b0;
    precision_sel = 2'b00;
    alu_op = 3'd0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    cmd_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_byte_ready", 32'(byte_ready), 32'd1);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_a", cmd_a, 32'd0);
    chk("rst_cmd_b", cmd_b, 32'd0);
    chk("rst_prec_op", {27'd0, cmd_prec, cmd_op}, 32'd0);
    chk("rst_errs", {30'd0, err_prec, err_timeout}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      send_vec(tbl[i]);
      drain();
    end

    // 8-bit timing: cmd_valid two cycles after first byte, one cycle long
    push(2'b00, 3'd0, 32'h12, 32'h34);
    precision_sel = 2'b00;
    alu_op = 3'd0;
    send_byte(8'h12);
    chk("t8_busy_a", 32'(busy), 32'd1);
    chk("t8_valid_early", 32'(cmd_valid), 32'd0);
    send_byte(8'h34);
    chk("t8_valid", 32'(cmd_valid), 32'd1);
    chk("t8_ready_low", 32'(byte_ready), 32'd0);
    tick();
    chk("t8_valid_drop", 32'(cmd_valid), 32'd0);
    chk("t8_ready_back", 32'(byte_ready), 32'd1);
    drain();

    // 32-bit with byte gaps and held backpressure
    cmd_ready = 1'b0;
    precision_sel = 2'b10;
    alu_op = 3'd1;
    push(2'b10, 3'd1, 32'h0403_0201, 32'h0807_0605);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i + 1));
      if (i < 7) begin
        tick();
        tick();
      end
    end
    chk("bp_valid", 32'(cmd_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_ready_low", 32'(byte_ready), 32'd0);
      chk("bp_a_hold", cmd_a, 32'h0403_0201);
      chk("bp_b_hold", cmd_b, 32'h0807_0605);
    end
    cmd_ready = 1'b1;
    tick();
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_ready_back", 32'(byte_ready), 32'd1);
    drain();

    // Illegal precision byte is dropped
    precision_sel = 2'b11;
    send_byte(8'hAA);
    chk("ill_err_prec", 32'(err_prec), 32'd1);
    chk("ill_busy", 32'(busy), 32'd0);
    tick();
    chk("ill_err_pulse", 32'(err_prec), 32'd0);
    chk("ill_no_valid", 32'(cmd_valid), 32'd0);
    send_vec(tbl[1]);
    drain();

    // Timeout after four stall cycles
    precision_sel = 2'b01;
    alu_op = 3'd4;
    send_byte(8'h77);
    repeat (3) tick();
    chk("to_still_busy", 32'(busy), 32'd1);
    tick();
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_a_clr", cmd_a, 32'd0);
    push(2'b00, 3'd2, 32'h5A, 32'hA5);
    precision_sel = 2'b00;
    alu_op = 3'd2;
    send_byte(8'h5A);
    chk("to_err_clr", 32'(err_timeout), 32'd0);
    send_byte(8'hA5);
    drain();

    // Precision/op changes after the first bytes are ignored
    push(2'b10, 3'd2, 32'h4433_2211, 32'h8877_6655);
    precision_sel = 2'b10;
    alu_op = 3'd2;
    send_byte(8'h11);
    send_byte(8'h22);
    precision_sel = 2'b00;
    alu_op = 3'd6;
    for (int i = 3; i <= 8; i++)
      send_byte(8'(i * 17));
    drain();

    // Reset in the middle of a 32-bit load
    precision_sel = 2'b10;
    alu_op = 3'd3;
    for (int i = 1; i <= 5; i++)
      send_byte(8'(i));
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_valid", 32'(cmd_valid), 32'd0);
    chk("mr_ready", 32'(byte_ready), 32'd1);
    chk("mr_a", cmd_a, 32'd0);
    chk("mr_b", cmd_b, 32'd0);
    chk("mr_prec_op", {27'd0, cmd_prec, cmd_op}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    push(2'b00, 3'd5, 32'hC3, 32'h3C);
    precision_sel = 2'b00;
    alu_op = 3'd5;
    send_byte(8'hC3);
    send_byte(8'h3C);
    drain();

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
